// File: rtl/serial_packet_tx.sv
// rtl/serial_packet_tx.sv - single-wire frame transmitter: start bit, {port,len} header, N payload bits, stop bit
module serial_packet_tx #(
  parameter int LEN_W  = 4,
  parameter int PORT_W = 2,
  parameter int DATA_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PORT_W-1:0] port,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] data,
  output logic              serout,
  output logic              busy,
  output logic              done
);

  localparam int HDR_W = PORT_W + LEN_W;
  localparam int CNT_W = $clog2(HDR_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    HDR   = 3'd2,
    PAY   = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [HDR_W-1:0]   hdr_q, hdr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   hdr_cnt_q, hdr_cnt_d;
  logic [LEN_W-1:0]   pay_cnt_q, pay_cnt_d;
  logic               serout_q, serout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // serout_d is the bit for the state being entered, so serout is a plain flop
  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    data_d    = data_q;
    len_d     = len_q;
    hdr_cnt_d = hdr_cnt_q;
    pay_cnt_d = pay_cnt_q;
    serout_d  = serout_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        serout_d = 1'b1;
        busy_d   = 1'b0;
        if (start) begin
          hdr_d    = {port, len};
          data_d   = data;
          len_d    = len;
          state_d  = START;
          serout_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      START: begin
        state_d   = HDR;
        hdr_cnt_d = '0;
        serout_d  = hdr_q[HDR_W-1];
      end
      HDR: begin
        if (hdr_cnt_q == CNT_W'(HDR_W-1)) begin
          if (len_q != '0) begin
            state_d   = PAY;
            pay_cnt_d = len_q;
            serout_d  = data_q[len_q - LEN_W'(1)];
          end else begin
            state_d  = STOP;
            serout_d = 1'b1;
          end
        end else begin
          hdr_cnt_d = hdr_cnt_q + CNT_W'(1);
          serout_d  = hdr_q[CNT_W'(HDR_W-2) - hdr_cnt_q];
        end
      end
      PAY: begin
        // pay_cnt_q counts bits remaining including the one on the wire
        if (pay_cnt_q == LEN_W'(1)) begin
          state_d  = STOP;
          serout_d = 1'b1;
        end else begin
          pay_cnt_d = pay_cnt_q - LEN_W'(1);
          serout_d  = data_q[pay_cnt_q - LEN_W'(2)];
        end
      end
      STOP: begin
        state_d  = IDLE;
        serout_d = 1'b1;
        busy_d   = 1'b0;
        done_d   = 1'b1;
      end
      default: begin
        state_d  = IDLE;
        serout_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      hdr_q     <= '0;
      data_q    <= '0;
      len_q     <= '0;
      hdr_cnt_q <= '0;
      pay_cnt_q <= '0;
      serout_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      data_q    <= data_d;
      len_q     <= len_d;
      hdr_cnt_q <= hdr_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      serout_q  <= serout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // a payload longer than the data register cannot be framed
  always_ff @(posedge clk) begin
    if (reset && state_q == IDLE && start) begin
      assert (int'(len) <= DATA_W);
    end
  end

  assign serout = serout_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
